// File: rtl/seg_reader_if.sv
// Bus between a multiplexed 7-segment display scanner and the frame reader.
// Handshake: value_valid is a one-cycle pulse with no ready; value/frame_err are only meaningful while it is high and hold between pulses.
interface seg_reader_if;
    logic [3:0]  an;
    logic [6:0]  led;
    logic [15:0] value;
    logic        value_valid;
    logic        frame_err;
    logic [1:0]  dbg_state;

    modport master (
        output an, led,
        input  value, value_valid, frame_err, dbg_state
    );

    modport slave (
        input  an, led,
        output value, value_valid, frame_err, dbg_state
    );
endinterface

// File: rtl/seg_reader.sv
// Recovers a 4-digit hex value by watching the anode/segment lines of a scanned display.
// A digit is accepted after STABLE_CYCLES identical samples; a frame completes once all four are captured.
module seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    seg_reader_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] S_BLANK = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   prev_q, prev_d;
    logic [3:0]    got_q, got_d;
    logic          err_q, err_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   value_q, value_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;

    logic [3:0]  nib;
    logic        illegal;
    logic        single;
    logic [1:0]  idx;
    logic [10:0] cur;
    logic        same;
    logic        capture;
    logic        frame_done;

    always_comb begin
        nib     = 4'h0;
        illegal = 1'b0;
        case (bus.led)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0001100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    illegal = 1'b1;
        endcase
    end

    // Only a one-hot-low anode selects a digit; anything else reads as blank.
    always_comb begin
        single = 1'b1;
        idx    = 2'd0;
        case (bus.an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    assign cur    = {bus.an, bus.led};
    assign same   = (cur == prev_q);
    assign prev_d = cur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (single) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            S_TRACK: begin
                if (!single) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end else if (same) begin
                    // Saturating: the run is captured the moment it reaches CNT_MAX.
                    if (cnt_q >= CNT_MAX - CNT_ONE) begin
                        cnt_d   = CNT_MAX;
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ONE;
                end
            end
            S_HOLD: begin
                if (!same) begin
                    if (single) begin
                        state_d = S_TRACK;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // A capture landing on the completion edge seeds the next frame rather than being cleared.
    always_comb begin
        frame_done  = (got_q == 4'hF);
        got_d       = frame_done ? 4'h0 : got_q;
        err_d       = frame_done ? 1'b0 : err_q;
        shadow_d    = shadow_q;
        value_d     = frame_done ? shadow_q : value_q;
        frame_err_d = frame_done ? err_q : frame_err_q;
        valid_d     = frame_done;
        if (capture) begin
            err_d = err_d | illegal;
            for (int i = 0; i < 4; i++) begin
                if (idx == 2'(i)) begin
                    got_d[i]          = 1'b1;
                    shadow_d[4*i +: 4] = nib;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_BLANK;
            cnt_q       <= '0;
            prev_q      <= '0;
            got_q       <= 4'h0;
            err_q       <= 1'b0;
            shadow_q    <= 16'h0000;
            value_q     <= 16'h0000;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            got_q       <= got_d;
            err_q       <= err_d;
            shadow_q    <= shadow_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader: scans hand-built display frames and scoreboards each value_valid pulse.
module tb_seg_reader;
    localparam logic [6:0] P1   = 7'b1001111;
    localparam logic [6:0] P2   = 7'b0010010;
    localparam logic [6:0] P3   = 7'b0000110;
    localparam logic [6:0] P4   = 7'b1001100;
    localparam logic [6:0] P5   = 7'b0100100;
    localparam logic [6:0] P6   = 7'b0100000;
    localparam logic [6:0] P8   = 7'b0000000;
    localparam logic [6:0] PA   = 7'b0001000;
    localparam logic [6:0] PB   = 7'b1100000;
    localparam logic [6:0] PE   = 7'b0110000;
    localparam logic [6:0] PF   = 7'b0111000;
    localparam logic [6:0] PILL = 7'b1111111;

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic clk;
    logic reset;
    seg_reader_if bus ();

    seg_reader #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int cyc      = 0;
    int valid_cyc = 0;
    logic [16:0] exp_q[$];

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // ---- drivers ----
    task automatic drive(input logic [3:0] a, input logic [6:0] l, input int n);
        bus.an  = a;
        bus.led = l;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] l0, input logic [6:0] l1,
                         input logic [6:0] l2, input logic [6:0] l3, input int n);
        drive(4'b1110, l0, n);
        drive(4'b1101, l1, n);
        drive(4'b1011, l2, n);
        drive(4'b0111, l3, n);
    endtask

    // ---- scoreboard: each pulse pops {frame_err, value} ----
    always @(negedge clk) begin
        if (!reset && bus.value_valid) begin
            logic [16:0] e;
            pulses++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_value", 32'(bus.value), 32'(e[15:0]));
                check("frame_err", 32'(bus.frame_err), 32'(e[16]));
            end
        end
    end

    initial begin
        int p0;
        int start_cyc;
        reset   = 1'b1;
        bus.an  = 4'b1111;
        bus.led = 7'h7F;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_valid", 32'(bus.value_valid), 32'h0);
        check("rst_err", 32'(bus.frame_err), 32'h0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_BLANK));
        reset = 1'b0;
        drive(4'b1111, 7'h7F, 2);

        // Basic frame 3,4,1,2 and its latency from the start of the scan.
        p0 = pulses;
        start_cyc = cyc;
        exp_q.push_back({1'b0, 16'h2143});
        scan4(P3, P4, P1, P2, 6);
        drive(4'b1111, 7'h7F, 4);
        check("t1_pulses", 32'(pulses - p0), 32'd1);
        check("t1_latency", 32'(valid_cyc - start_cyc), 32'd23);
        check("t1_value_held", 32'(bus.value), 32'h2143);

        // Illegal pattern on digit 2.
        p0 = pulses;
        exp_q.push_back({1'b1, 16'h2043});
        scan4(P3, P4, PILL, P2, 6);
        drive(4'b1111, 7'h7F, 4);
        check("t2_pulses", 32'(pulses - p0), 32'd1);
        check("t2_err_held", 32'(bus.frame_err), 32'd1);

        // Glitches shorter than the stability window are ignored.
        p0 = pulses;
        exp_q.push_back({1'b0, 16'h214A});
        drive(4'b1110, P8, 2);
        drive(4'b1110, PA, 6);
        drive(4'b1101, P8, 3);
        drive(4'b1101, P4, 6);
        drive(4'b1011, P1, 6);
        drive(4'b0111, P2, 6);
        drive(4'b1111, 7'h7F, 4);
        check("t3_pulses", 32'(pulses - p0), 32'd1);

        // Blank anode combinations never capture.
        p0 = pulses;
        drive(4'b1100, P8, 20);
        drive(4'b1111, P3, 20);
        drive(4'b0000, P1, 5);
        check("t4_pulses", 32'(pulses - p0), 32'd0);
        check("t4_state", 32'(bus.dbg_state), 32'(ST_BLANK));
        check("t4_value_held", 32'(bus.value), 32'h214A);

        // Reset mid-frame discards partial captures, including the error bit.
        p0 = pulses;
        drive(4'b1110, PILL, 6);
        drive(4'b1101, P4, 6);
        drive(4'b1011, P1, 6);
        check("t5_no_pulse_pre", 32'(pulses - p0), 32'd0);
        reset = 1'b1;
        #2;
        check("t5_async_value", 32'(bus.value), 32'h0);
        check("t5_async_state", 32'(bus.dbg_state), 32'(ST_BLANK));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 7'h7F, 2);
        p0 = pulses;
        exp_q.push_back({1'b0, 16'hBEEF});
        drive(4'b0111, PB, 6);
        drive(4'b1110, PF, 6);
        drive(4'b1101, PE, 6);
        drive(4'b1011, PE, 6);
        drive(4'b1111, 7'h7F, 4);
        check("t5_pulses", 32'(pulses - p0), 32'd1);

        // One digit held for 100 cycles captures only once.
        p0 = pulses;
        exp_q.push_back({1'b0, 16'h2143});
        exp_q.push_back({1'b0, 16'h2143});
        drive(4'b1110, P3, 50);
        check("t6_hold_state", 32'(bus.dbg_state), 32'(ST_HOLD));
        drive(4'b1110, P3, 50);
        drive(4'b1101, P4, 6);
        drive(4'b1011, P1, 6);
        drive(4'b0111, P2, 6);
        check("t6_pulses_one", 32'(pulses - p0), 32'd1);
        scan4(P3, P4, P1, P2, 6);
        drive(4'b1111, 7'h7F, 4);
        check("t6_pulses_two", 32'(pulses - p0), 32'd2);

        // Recapture overwrites the slot; the error bit stays accumulated.
        p0 = pulses;
        exp_q.push_back({1'b1, 16'h2146});
        drive(4'b1110, P5, 6);
        drive(4'b1110, P6, 6);
        drive(4'b1101, PILL, 6);
        drive(4'b1101, P4, 6);
        drive(4'b1011, P1, 6);
        drive(4'b0111, P2, 6);
        drive(4'b1111, 7'h7F, 4);
        check("t7_pulses", 32'(pulses - p0), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
